// File: rtl/arith_pkg.sv
// arith_pkg: state encoding and default width shared by the iterative arithmetic units
package arith_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;
  localparam int ARITH_W = 8;
endpackage

// File: rtl/mul_unsign.sv
// mul_unsign: iterative unsigned shift-and-add multiplier, one multiplier bit per clock
module mul_unsign
  import arith_pkg::*;
#(
  parameter int W = ARITH_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   X,
  input  logic [W-1:0]   Y,
  output logic           busy,
  output logic           data_ok,
  output logic [2*W-1:0] P
);
  localparam int CW = $clog2(W + 1);
  state_t         state, state_n;
  logic [2*W-1:0] mc, mc_n, p_n;
  logic [W-1:0]   mr, mr_n;
  logic [CW-1:0]  count, count_n;
  logic           data_ok_n, accept;
  assign busy   = state == S_CALC;
  assign accept = start && state != S_CALC;
  always_comb begin
    state_n   = state;
    mc_n      = mc;
    mr_n      = mr;
    p_n       = P;
    count_n   = count;
    data_ok_n = data_ok;
    if (accept) begin
      mc_n      = {{W{1'b0}}, X};
      mr_n      = Y;
      p_n       = '0;
      count_n   = '0;
      data_ok_n = 1'b0;
      state_n   = S_CALC;
    end else if (state == S_CALC) begin
      p_n     = mr[0] ? P + mc : P;
      mc_n    = mc << 1;
      mr_n    = mr >> 1;
      count_n = count + 1'b1;
      // fixed W iterations keeps latency independent of the operands
      if (count_n == CW'(W)) begin
        state_n   = S_DONE;
        data_ok_n = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      mc      <= '0;
      mr      <= '0;
      P       <= '0;
      count   <= '0;
      data_ok <= 1'b0;
    end else begin
      state   <= state_n;
      mc      <= mc_n;
      mr      <= mr_n;
      P       <= p_n;
      count   <= count_n;
      data_ok <= data_ok_n;
    end
  end
endmodule
